// File: rtl/scalar_rf_perf.sv
// Purpose: scalar register file (NRD comb reads, 1 write, R0 = 0) with perf counters and a CPI divider.
// Latency: reads 0 cycles; writes and counters visible next cycle; CPI refreshes every CNT_W+FRAC+2 cycles.
// Backpressure: none; every input is accepted each cycle. Optional SRF_BYPASS_EN adds write-to-read forwarding.
module scalar_rf_perf #(
  parameter int WIDTH      = 19,
  parameter int NREGS      = 32,
  parameter int NRD        = 3,
  parameter int CNT_W      = 32,
  parameter int FRAC       = 4,
  parameter int INIT_R1    = 220500,
  parameter int INIT_R10   = 224,
  parameter int FINISH_REG = 28,
  parameter int FINISH_VAL = 333,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*AW-1:0]      rs,
  output logic [NRD*WIDTH-1:0]   rdata,
  input  logic [AW-1:0]          rd_addr,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   we,
  input  logic                   ev_retire,
  input  logic                   ev_stall,
  input  logic                   ev_arith,
  input  logic                   ev_mem,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       arith_cnt,
  output logic [CNT_W-1:0]       mem_cnt,
  output logic [WIDTH-1:0]       cpi,
  output logic                   cpi_valid,
  output logic                   finish
);

  localparam int QW = CNT_W + FRAC;
  localparam int BW = $clog2(QW);
  // One bit wider than both quotient and result so the saturation compare never overflows.
  localparam int XW = ((QW > WIDTH) ? QW : WIDTH) + 1;

  localparam logic [WIDTH-1:0] R1_SEED  = WIDTH'(INIT_R1);
  localparam logic [WIDTH-1:0] R10_SEED = WIDTH'(INIT_R10);
  localparam logic [WIDTH-1:0] FIN_VAL  = WIDTH'(FINISH_VAL);
  localparam logic [AW-1:0]    FIN_IDX  = AW'(FINISH_REG);
  localparam bit               FIN_EN   = (FINISH_REG > 0) && (FINISH_REG < NREGS);
  localparam logic [XW-1:0]    CPI_MAX  = {{(XW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  logic [WIDTH-1:0] regs [NREGS];

  state_t           state, state_nxt;
  logic [QW-1:0]    n_q;
  logic [QW-1:0]    q_q;
  logic [CNT_W-1:0] d_q;
  logic [CNT_W-1:0] r_q;
  logic [BW-1:0]    bit_cnt;

  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;
  logic             ge;
  logic [CNT_W-1:0] r_nxt;
  logic [QW-1:0]    q_nxt;
  logic [XW-1:0]    q_ext;
  logic [WIDTH-1:0] cpi_sat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Register array: seeded at reset, R0 never written so it stays zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == 1) ? R1_SEED : (i == 10) ? R10_SEED : '0;
      end
    end else if (we && (rd_addr != '0)) begin
      regs[rd_addr] <= wd;
    end
  end

  // Combinational read ports; address 0 is forced to zero.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rs[p*AW +: AW];
`ifdef SRF_BYPASS_EN
    assign rdata[p*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                     (we && (rd_addr == addr)) ? wd : regs[addr];
`else
    assign rdata[p*WIDTH +: WIDTH] = (addr == '0) ? '0 : regs[addr];
`endif
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      arith_cnt  <= '0;
      mem_cnt    <= '0;
    end else begin
      cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
      retire_cnt <= sat_inc(retire_cnt, ev_retire);
      stall_cnt  <= sat_inc(stall_cnt, ev_stall);
      arith_cnt  <= sat_inc(arith_cnt, ev_arith);
      mem_cnt    <= sat_inc(mem_cnt, ev_mem);
    end
  end

  // One restoring-division step; remainder always stays below D so CNT_W bits hold it.
  always_comb begin
    trial   = {r_q, n_q[QW-1]};
    diff    = trial - {1'b0, d_q};
    ge      = (trial >= {1'b0, d_q});
    r_nxt   = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    q_nxt   = {q_q[QW-2:0], ge};
    q_ext   = {{(XW-QW){1'b0}}, q_nxt};
    cpi_sat = (q_ext > CPI_MAX) ? {WIDTH{1'b1}} : q_ext[WIDTH-1:0];
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Divider next state; cpi_valid is high only in DONE.
  always_comb begin
    state_nxt = state;
    cpi_valid = 1'b0;
    case (state)
      S_IDLE: if (retire_cnt != '0) state_nxt = S_DIV;
      S_DIV:  if (bit_cnt == '0) state_nxt = S_DONE;
      S_DONE: begin
        cpi_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath: snapshot in IDLE, iterate in DIV, publish cpi on the last step so it is stable during DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      bit_cnt <= '0;
      cpi     <= '0;
    end else begin
      case (state)
        S_IDLE: if (retire_cnt != '0) begin
          n_q     <= {cycle_cnt, {FRAC{1'b0}}};
          d_q     <= retire_cnt;
          r_q     <= '0;
          q_q     <= '0;
          bit_cnt <= BW'(QW - 1);
        end
        S_DIV: begin
          n_q     <= {n_q[QW-2:0], 1'b0};
          r_q     <= r_nxt;
          q_q     <= q_nxt;
          bit_cnt <= bit_cnt - BW'(1);
          if (bit_cnt == '0) cpi <= cpi_sat;
        end
        default: ;
      endcase
    end
  end

  // Sticky program-end flag; the write-path term makes it rise right after the committing edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      finish <= 1'b0;
    end else if (FIN_EN) begin
      finish <= finish || (regs[FIN_IDX] == FIN_VAL) ||
                (we && (rd_addr == FIN_IDX) && (wd == FIN_VAL));
    end
  end

endmodule

// File: tb/tb_scalar_rf_perf.sv
module tb_scalar_rf_perf;
  localparam int WIDTH = 19;
  localparam int AW    = 5;
  localparam int NRD   = 3;
  localparam int CNT_W = 32;
  localparam int QW    = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRD*AW-1:0]    rs = '0;
  logic [NRD*WIDTH-1:0] rdata, rdata2;
  logic [AW-1:0]        rd_addr = '0;
  logic [WIDTH-1:0]     wd = '0;
  logic                 we = 1'b0;
  logic ev_retire = 1'b0, ev_stall = 1'b0, ev_arith = 1'b0, ev_mem = 1'b0;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt, arith_cnt, mem_cnt;
  logic [WIDTH-1:0] cpi, cpi2;
  logic             cpi_valid, cpi_valid2, finish, finish2;
  logic [7:0]       cyc2, ret2, stall2, arith2, mem2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scalar_rf_perf dut (
    .clk(clk), .rst(rst), .rs(rs), .rdata(rdata), .rd_addr(rd_addr), .wd(wd), .we(we),
    .ev_retire(ev_retire), .ev_stall(ev_stall), .ev_arith(ev_arith), .ev_mem(ev_mem),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .arith_cnt(arith_cnt), .mem_cnt(mem_cnt), .cpi(cpi), .cpi_valid(cpi_valid), .finish(finish)
  );

  scalar_rf_perf #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .rs(rs), .rdata(rdata2), .rd_addr(rd_addr), .wd(wd), .we(we),
    .ev_retire(ev_retire), .ev_stall(ev_stall), .ev_arith(ev_arith), .ev_mem(ev_mem),
    .cycle_cnt(cyc2), .retire_cnt(ret2), .stall_cnt(stall2),
    .arith_cnt(arith2), .mem_cnt(mem2), .cpi(cpi2), .cpi_valid(cpi_valid2), .finish(finish2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rs = {a2, a1, a0};
  endtask

  function automatic logic [WIDTH-1:0] port(input int p);
    return rdata[p*WIDTH +: WIDTH];
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int np;
    int pcyc [3];
    logic [WIDTH-1:0] pval [3];
    int seen;
    int n;

    // ---------------- reset state ----------------
    set_rs(5'd1, 5'd10, 5'd5);
    tick(); tick(); tick();
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_arith_cnt", arith_cnt, 0);
    chk("rst_mem_cnt", mem_cnt, 0);
    chk("rst_cpi", cpi, 0);
    chk("rst_cpi_valid", cpi_valid, 0);
    chk("rst_finish", finish, 0);
    rst = 1'b1;
    tick();
    chk("cycle_after_release", cycle_cnt, 1);
    chk("rd_r1_seed", port(0), 220500);
    chk("rd_r10_seed", port(1), 224);
    chk("rd_r5_zero", port(2), 0);

    // ---------------- R0 and write/read ----------------
    set_rs(5'd0, 5'd7, 5'd1);
    we = 1'b1; rd_addr = 5'd0; wd = 19'h1ABCD;
    tick();
    we = 1'b0;
    #1;
    chk("r0_stays_zero", port(0), 0);
    we = 1'b1; rd_addr = 5'd7; wd = 19'h1ABCD;
    #1;
`ifdef SRF_BYPASS_EN
    chk("r7_write_cycle", port(1), 19'h1ABCD);
`else
    chk("r7_write_cycle", port(1), 0);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("r7_after_write", port(1), 19'h1ABCD);
    chk("r1_untouched", port(2), 220500);
    we = 1'b1; rd_addr = 5'd31; wd = 19'h7FFFF;
    tick();
    we = 1'b0;
    set_rs(5'd31, 5'd7, 5'd31);
    #1;
    chk("r31_port0", port(0), 19'h7FFFF);
    chk("r31_port2", port(2), 19'h7FFFF);

    // ---------------- event counters ----------------
    ev_arith = 1'b1; ev_mem = 1'b1; ev_retire = 1'b1;
    tick();
    ev_arith = 1'b0; ev_mem = 1'b0; ev_retire = 1'b0;
    chk("ev_arith_1", arith_cnt, 1);
    chk("ev_mem_1", mem_cnt, 1);
    chk("ev_retire_1", retire_cnt, 1);
    chk("ev_stall_0", stall_cnt, 0);
    ev_stall = 1'b1; ev_arith = 1'b1;
    tick();
    ev_stall = 1'b0; ev_arith = 1'b0;
    chk("ev_stall_1", stall_cnt, 1);
    chk("ev_arith_2", arith_cnt, 2);

    // ---------------- finish ----------------
    set_rs(5'd28, 5'd0, 5'd0);
    we = 1'b1; rd_addr = 5'd28; wd = 19'd333;
    #1;
    chk("finish_before_write", finish, 0);
    tick();
    we = 1'b0;
    chk("finish_set", finish, 1);
    we = 1'b1; rd_addr = 5'd28; wd = 19'd0;
    tick();
    we = 1'b0;
    tick();
    chk("finish_sticky", finish, 1);
    chk("r28_cleared", port(0), 0);

    // ---------------- CPI: one retire every 4 cycles from reset ----------------
    do_reset();
    chk("finish_cleared_by_rst", finish, 0);
    np = 0;
    for (int k = 1; k <= 200 && np < 3; k++) begin
      ev_retire = ((k % 4) == 0);
      @(posedge clk);
      #2;
      if (cpi_valid) begin
        pcyc[np] = k;
        pval[np] = cpi;
        np++;
      end
    end
    ev_retire = 1'b0;
    chk("cpi_pulse_count", np, 3);
    if (np == 3) begin
      chk("cpi_first_exact", pval[0], 64);
      chk("cpi_spacing_1", pcyc[1] - pcyc[0], 38);
      chk("cpi_spacing_2", pcyc[2] - pcyc[1], 38);
      for (int i = 0; i < 3; i++)
        chk("cpi_near_4p0", (pval[i] >= 48) && (pval[i] <= 80), 1);
    end

    // ---------------- abort mid-DIV ----------------
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      ev_retire = (k == 4);
      tick();
    end
    ev_retire = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_valid_low", cpi_valid, 0);
    chk("abort_cpi_zero", cpi, 0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (cpi_valid) seen++;
    end
    chk("abort_no_pulse", seen, 0);
    chk("abort_cpi_still_zero", cpi, 0);
    ev_retire = 1'b1;
    tick();
    ev_retire = 1'b0;
    chk("abort_retire_first", retire_cnt, 1);
    n = 1;
    for (int k = 0; k < 100 && !cpi_valid; k++) begin
      tick();
      n++;
    end
    chk("abort_valid_seen", cpi_valid, 1);
    chk("abort_first_latency", n, QW + 2);

    // ---------------- saturation (CNT_W=8 instance) ----------------
    ev_stall = 1'b1;
    repeat (300) tick();
    chk("sat_stall_255", stall2, 255);
    repeat (5) tick();
    ev_stall = 1'b0;
    tick();
    chk("sat_stall_holds", stall2, 255);
    chk("sat_cycle_255", cyc2, 255);
    chk("wide_stall_305", stall_cnt, 305);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scalar_rf_perf.md
# scalar_rf_perf

Parametrised second-generation scalar register file for the vector/scalar processor's decode stage. It provides NRD combinational read ports and one write port, with a hardwired-zero R0 and configurable reset seeds. It also contains its own performance-counter bank: cycles, retired instructions, stalls, arithmetic ops and memory ops. Cycles-per-instruction is computed by an internal multi-cycle fixed-point divider instead of a combinational divide.

## Interface
- WIDTH, 19, register data width
- NREGS, 32, number of registers (power of two, ≥ 16); AW = $clog2(NREGS)
- NRD, 3, number of read ports
- CNT_W, 32, performance-counter width
- FRAC, 4, fractional bits of the CPI result
- INIT_R1, 220500, reset value of R1
- INIT_R10, 224, reset value of R10
- FINISH_REG, 28, register watched for program end
- FINISH_VAL, 333, value that signals program end

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-low
- rs  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rdata  out  NRD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH]
- rd_addr  in  AW  write address
- wd  in  WIDTH  write data
- we  in  1  write enable
- ev_retire, ev_stall, ev_arith, ev_mem  in  1 each  one-cycle event pulses
- cycle_cnt, retire_cnt, stall_cnt, arith_cnt, mem_cnt  out  CNT_W each  counter values
- cpi  out  WIDTH  cycles per instruction, unsigned fixed point with FRAC fractional bits
- cpi_valid  out  1  one-cycle pulse when cpi updates
- finish  out  1  sticky program-end flag

## Operation
- Reset (rst=0 at an edge):
  - All registers are 0, except R1=INIT_R1 and R10=INIT_R10.
  - All counters are 0, cpi=0, cpi_valid=0, finish=0, divider is in IDLE.
- Read:
  - rdata is combinational from rs.
  - R0 always reads 0.
- Write:
  - When we=1, R[rd_addr] takes wd at the edge.
  - Writes to R0 are ignored.
  - Initialisation values are truncated to WIDTH.
- Counters:
  - cycle_cnt increments every cycle out of reset.
  - Each ev_* pulse increments its counter by 1 at that edge.
  - All counters saturate at 2^CNT_W−1; they never wrap.
- Divider states:
  - IDLE: if retire_cnt≠0, snapshot N = cycle_cnt<<FRAC and D = retire_cnt, then go to DIV. Otherwise stay in IDLE; cpi holds its value.
  - DIV: restoring divider, one quotient bit per cycle, QW = CNT_W+FRAC iterations, then go to DONE.
  - DONE: cpi ← quotient, saturated to 2^WIDTH−1 if it exceeds WIDTH bits. cpi_valid=1 for this cycle only. Go to IDLE.
  - Snapshots are used throughout a computation, so counter changes during DIV do not affect the result in flight.
- finish:
  - Set once R[FINISH_REG]==FINISH_VAL; stays 1 until reset, even if the register changes later.
  - finish=0 always if FINISH_REG ≥ NREGS or FINISH_REG = 0.

## Timing
- Read latency: 0 cycles (combinational).
- Write: visible on rdata from the cycle after the write edge (same cycle with bypass; see Configuration).
- Counters: value visible the cycle after the event edge.
- CPI update period: QW+2 cycles (IDLE, QW×DIV, DONE) while retire_cnt≠0.
  - With defaults that is 38 cycles.
  - cpi_valid rises every 38 cycles.
- finish: rises the cycle after the write of FINISH_VAL to FINISH_REG commits.
- Reset mid-operation:
  - Reset in DIV aborts the divide; the result is discarded and no cpi_valid pulse is produced.
  - rst is sampled only at clk edges.
- Simultaneous events:
  - Any combination of ev_* pulses in one cycle increments every pulsed counter.
  - we together with a read of the same address: see Configuration.

## Configuration
- SRF_BYPASS_EN defined:
  - A read port whose address equals rd_addr while we=1 and rd_addr≠0 returns wd in the same cycle (write-to-read forwarding).
- SRF_BYPASS_EN undefined:
  - That port returns the old stored value.
  - No forwarding logic is present.

## Test plan
- Reset:
  - Release rst and read R1, R10 and R5 -> 220500, 224 and 0.
  - All counters, cpi, cpi_valid and finish are 0.
- R0 and write/read:
  - Write 0x1ABCD to R0 -> it reads 0.
  - Write 0x1ABCD to R7 -> R7 reads 0x1ABCD the next cycle.
  - With SRF_BYPASS_EN, R7 also reads 0x1ABCD on the write cycle itself.
- CPI:
  - Pulse ev_retire once per 4 cycles from reset, defaults -> each cpi_valid pulse shows cpi ≈ 4.0 (value 64 ±16).
  - cpi_valid pulses are spaced exactly 38 cycles apart.
- Finish:
  - Write 333 to R28 -> finish=1 on the following cycle.
  - Then write 0 to R28 -> finish stays 1.
- Saturation (CNT_W=8):
  - Hold ev_stall high for 300 cycles -> stall_cnt=255 and stays there.
- Abort:
  - Assert rst mid-DIV -> no cpi_valid pulse; cpi=0.
  - After release, the first cpi_valid appears no earlier than QW+2 cycles after retire_cnt first becomes nonzero.
